// File: rtl/core_lane_if.sv
// Instruction, data-RAM and debug signals of one execution lane.
// The lane takes the slave view; the instruction source / RAM side takes the master view.
interface core_lane_if #(
  parameter int WIDTH   = 16,
  parameter int INSTR_W = 15
);
  logic [INSTR_W-1:0] instr_in;
  logic               instr_valid;
  logic               instr_ready;
  logic [WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]   mem_wdata;
  logic               mem_we;
  logic [WIDTH-1:0]   mem_rdata;
  logic [3:0]         flags;
  logic [1:0]         dbg_sel;
  logic [WIDTH-1:0]   dbg_data;

  modport slave (
    input  instr_in, instr_valid, mem_rdata, dbg_sel,
    output instr_ready, mem_addr, mem_wdata, mem_we, flags, dbg_data
  );

  modport master (
    output instr_in, instr_valid, mem_rdata, dbg_sel,
    input  instr_ready, mem_addr, mem_wdata, mem_we, flags, dbg_data
  );
endinterface

// File: rtl/core_lane.sv
// Per-core execution lane: conditional ALU/move/load/store on a 4-entry register file,
// with a three-cycle load path through an external synchronous single-port RAM.
module core_lane #(
  parameter int WIDTH   = 16,
  parameter int INSTR_W = 15
) (
  input  logic        clock,
  input  logic        reset,
  core_lane_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LD_ADDR, LD_DATA} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   regs_q [4];
  logic [WIDTH-1:0]   regs_d [4];
  logic [3:0]         flags_q, flags_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic [1:0]         ld_dst_q, ld_dst_d;

  logic [INSTR_W-1:0] instr;
  logic               is_alu;
  logic [3:0]         op, suffix;
  logic [1:0]         dst, src;
  logic [WIDTH-1:0]   a_val, b_val;
  logic               unused_reserved;

  assign instr           = bus.instr_in;
  assign is_alu          = instr[14];
  assign op              = instr[13:10];
  assign suffix          = instr[9:6];
  assign dst             = instr[3:2];
  assign src             = instr[1:0];
  assign unused_reserved = ^instr[5:4];
  assign a_val           = regs_q[dst];
  assign b_val           = regs_q[src];

  // flags are {Z,O,S,C}
  function automatic logic cond_eval(input logic [3:0] suf, input logic [3:0] f);
    logic z, o, s, c;
    z = f[3]; o = f[2]; s = f[1]; c = f[0];
    case (suf)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = !z && (s == o);
      4'b0011: cond_eval = (s != o);
      4'b0100: cond_eval = (s == o);
      4'b0101: cond_eval = z || (s != o);
      4'b0110: cond_eval = c;
      4'b0111: cond_eval = !c;
      4'b1000: cond_eval = s;
      4'b1001: cond_eval = !s;
      4'b1010: cond_eval = 1'b1;
      4'b1011: cond_eval = 1'b0;
      4'b1100: cond_eval = o;
      4'b1101: cond_eval = !o;
      4'b1110: cond_eval = c && !z;
      default: cond_eval = !c || z;
    endcase
  endfunction

  logic cond_true;
  assign cond_true = cond_eval(suffix, flags_q);

  // inc/dec reuse the add/sub datapath with a constant 1 as the second operand
  logic [WIDTH-1:0]          opb;
  logic                      carry_in;
  logic [WIDTH:0]            add_ext, sub_ext, lsl_ext, lsr_ext;
  logic signed [WIDTH:0]     asr_ext;
  logic [2*WIDTH-1:0]        mul_full;
  logic [3:0]                amt;

  assign opb      = (op == 4'b1110 || op == 4'b1111) ? WIDTH'(1) : b_val;
  assign carry_in = (op == 4'b0001 || op == 4'b0011 || op == 4'b0101) ? flags_q[0] : 1'b0;
  assign add_ext  = {1'b0, a_val} + {1'b0, opb} + {{WIDTH{1'b0}}, carry_in};
  assign sub_ext  = {1'b0, a_val} - {1'b0, opb} - {{WIDTH{1'b0}}, carry_in};
  assign mul_full = ({{WIDTH{1'b0}}, a_val} * {{WIDTH{1'b0}}, b_val})
                  + {{(2*WIDTH-1){1'b0}}, carry_in};
  assign amt      = b_val[3:0];
  assign lsl_ext  = {1'b0, a_val} << amt;
  assign lsr_ext  = {a_val, 1'b0} >> amt;
  assign asr_ext  = $signed({a_val, 1'b0}) >>> amt;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_o, alu_wr;
  logic [3:0]       alu_flags;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_wr  = 1'b1;
    case (op)
      4'b0000, 4'b0001, 4'b1110: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_o   = (a_val[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != a_val[WIDTH-1]);
      end
      4'b0010, 4'b0011, 4'b1101, 4'b1111: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_o   = (a_val[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != a_val[WIDTH-1]);
        alu_wr  = (op != 4'b1101);
      end
      4'b0100, 4'b0101: begin
        alu_res = mul_full[WIDTH-1:0];
        alu_c   = |mul_full[2*WIDTH-1:WIDTH];
        alu_o   = alu_c;
      end
      4'b0110: alu_res = a_val & b_val;
      4'b0111: alu_res = a_val | b_val;
      4'b1000: alu_res = a_val ^ b_val;
      4'b1001: alu_res = ~b_val;
      4'b1010: begin
        alu_res = lsl_ext[WIDTH-1:0];
        alu_c   = lsl_ext[WIDTH];
      end
      4'b1011: begin
        alu_res = lsr_ext[WIDTH:1];
        alu_c   = lsr_ext[0];
      end
      default: begin
        alu_res = asr_ext[WIDTH:1];
        alu_c   = asr_ext[0];
      end
    endcase
    alu_flags = {(alu_res == '0), alu_o, alu_res[WIDTH-1], alu_c};
  end

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    ld_dst_d    = ld_dst_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid && cond_true) begin
          if (is_alu) begin
            if (alu_wr) regs_d[dst] = alu_res;
            flags_d = alu_flags;
          end else begin
            case (op)
              4'b0000: begin
                mem_addr_d = b_val;
                ld_dst_d   = dst;
                state_d    = LD_ADDR;
              end
              4'b0001: begin
                mem_addr_d  = b_val;
                mem_wdata_d = a_val;
                mem_we_d    = 1'b1;
              end
              4'b0010: regs_d[dst] = b_val;
              default: ;
            endcase
          end
        end
      end
      LD_ADDR: state_d = LD_DATA;
      LD_DATA: begin
        regs_d[ld_dst_q] = bus.mem_rdata;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      flags_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      ld_dst_q    <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      ld_dst_q    <= ld_dst_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.flags       = flags_q;
  assign bus.dbg_data    = regs_q[bus.dbg_sel];
endmodule

// File: tb/tb_core_lane.sv
// Directed bench for core_lane with a behavioural synchronous single-port RAM.
module tb_core_lane;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  localparam logic [3:0] AL = 4'b1010;
  localparam logic [14:0] NOP = 15'b1_0000_1011_00_00_00;

  core_lane_if #(.WIDTH(16), .INSTR_W(15)) bus();
  core_lane #(.WIDTH(16), .INSTR_W(15)) dut (.clock(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  function automatic logic [14:0] enc(input logic t, input logic [3:0] op, input logic [3:0] suf,
                                      input logic [1:0] d, input logic [1:0] s);
    return {t, op, suf, 2'b00, d, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [15:0] exp);
    bus.dbg_sel = idx;
    #1;
    chk(tag, {16'h0, bus.dbg_data}, {16'h0, exp});
  endtask

  task automatic issue(input string tag, input logic [14:0] ins);
    bus.instr_in    = ins;
    bus.instr_valid = 1'b1;
    $display("txn %s instr=%h", tag, ins);
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [14:0] ins, input logic [1:0] d,
                         input logic [15:0] exp);
    issue(tag, ins);
    chk({tag, "_rdy0"}, {31'h0, bus.instr_ready}, 32'h0);
    step();
    chk({tag, "_rdy1"}, {31'h0, bus.instr_ready}, 32'h0);
    step();
    chk({tag, "_rdy2"}, {31'h0, bus.instr_ready}, 32'h1);
    chk_reg({tag, "_val"}, d, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    ram[0] = 16'h0001;
    ram[1] = 16'h7FFF;
    ram[4] = 16'hABCD;
    ram[5] = 16'h0010;
    rst = 1'b1;
    bus.instr_in = NOP;
    bus.instr_valid = 1'b0;
    bus.dbg_sel = 2'd0;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    chk("rst_ready", {31'h0, bus.instr_ready}, 32'h1);
    chk("rst_flags", {28'h0, bus.flags}, 32'h0);
    chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_addr", {16'h0, bus.mem_addr}, 32'h0);
    chk("rst_wdata", {16'h0, bus.mem_wdata}, 32'h0);
    for (int r = 0; r < 4; r++) chk_reg("rst_reg", 2'(r), 16'h0);

    // r1 <- RAM[r0=0] = 1, then r0 <- RAM[r1=1] = 0x7FFF
    do_load("ld_r1", enc(1'b0, 4'b0000, AL, 2'd1, 2'd0), 2'd1, 16'h0001);
    do_load("ld_r0", enc(1'b0, 4'b0000, AL, 2'd0, 2'd1), 2'd0, 16'h7FFF);
    chk("ld_addr", {16'h0, bus.mem_addr}, 32'h1);

    issue("addal", enc(1'b1, 4'b0000, AL, 2'd0, 2'd1));
    chk_reg("addal_r0", 2'd0, 16'h8000);
    chk("addal_flags", {28'h0, bus.flags}, 32'h6);

    // Z=0 so addeq is skipped
    issue("addeq", enc(1'b1, 4'b0000, 4'b0000, 2'd0, 2'd1));
    chk("addeq_ready", {31'h0, bus.instr_ready}, 32'h1);
    issue("nop", NOP);
    chk_reg("addeq_r0", 2'd0, 16'h8000);
    chk("addeq_flags", {28'h0, bus.flags}, 32'h6);
    chk("nop_ready", {31'h0, bus.instr_ready}, 32'h1);

    issue("xor_r2r2", enc(1'b1, 4'b1000, AL, 2'd2, 2'd2));
    chk_reg("xor_r2", 2'd2, 16'h0);
    chk("xor_flags", {28'h0, bus.flags}, 32'h8);
    for (int k = 0; k < 3; k++) issue("inc_r2", enc(1'b1, 4'b1110, AL, 2'd2, 2'd0));
    issue("mov_r3", enc(1'b0, 4'b0010, AL, 2'd3, 2'd2));
    chk_reg("mov_r3", 2'd3, 16'h0003);
    for (int k = 0; k < 2; k++) issue("inc_r3", enc(1'b1, 4'b1110, AL, 2'd3, 2'd0));
    chk_reg("inc_r3", 2'd3, 16'h0005);

    issue("subal", enc(1'b1, 4'b0010, AL, 2'd2, 2'd3));
    chk_reg("subal_r2", 2'd2, 16'hFFFE);
    chk("subal_flags", {28'h0, bus.flags}, 32'h3);
    issue("subcal", enc(1'b1, 4'b0011, AL, 2'd2, 2'd3));
    chk_reg("subcal_r2", 2'd2, 16'hFFF8);
    chk("subcal_flags", {28'h0, bus.flags}, 32'h2);

    do_load("ld_r2", enc(1'b0, 4'b0000, AL, 2'd2, 2'd3), 2'd2, 16'h0010);
    issue("dec_r3", enc(1'b1, 4'b1111, AL, 2'd3, 2'd0));
    chk_reg("dec_r3", 2'd3, 16'h0004);
    do_load("ld_r1b", enc(1'b0, 4'b0000, AL, 2'd1, 2'd3), 2'd1, 16'hABCD);

    // back-to-back stores keep mem_we high
    issue("st_r1", enc(1'b0, 4'b0001, AL, 2'd1, 2'd2));
    chk("st1_we", {31'h0, bus.mem_we}, 32'h1);
    chk("st1_addr", {16'h0, bus.mem_addr}, 32'h0010);
    chk("st1_wdata", {16'h0, bus.mem_wdata}, 32'hABCD);
    issue("st_r3", enc(1'b0, 4'b0001, AL, 2'd3, 2'd1));
    chk("st2_we", {31'h0, bus.mem_we}, 32'h1);
    chk("st2_addr", {16'h0, bus.mem_addr}, 32'hABCD);
    chk("st2_wdata", {16'h0, bus.mem_wdata}, 32'h0004);
    step();
    chk("st_we_off", {31'h0, bus.mem_we}, 32'h0);
    chk("st_addr_hold", {16'h0, bus.mem_addr}, 32'hABCD);

    do_load("ld_r3", enc(1'b0, 4'b0000, AL, 2'd3, 2'd2), 2'd3, 16'hABCD);

    // ALU op held on the bus during a load is taken only after writeback
    bus.instr_in = enc(1'b0, 4'b0000, AL, 2'd0, 2'd2);
    bus.instr_valid = 1'b1;
    $display("txn ld_r0_held instr=%h", bus.instr_in);
    step();
    chk("held_rdy0", {31'h0, bus.instr_ready}, 32'h0);
    bus.instr_in = enc(1'b1, 4'b1110, AL, 2'd0, 2'd0);
    $display("txn inc_r0_held instr=%h", bus.instr_in);
    step();
    chk("held_rdy1", {31'h0, bus.instr_ready}, 32'h0);
    step();
    chk("held_rdy2", {31'h0, bus.instr_ready}, 32'h1);
    chk_reg("held_ld_r0", 2'd0, 16'hABCD);
    step();
    bus.instr_valid = 1'b0;
    chk_reg("held_inc_r0", 2'd0, 16'hABCE);

    issue("lsl", enc(1'b1, 4'b1010, AL, 2'd0, 2'd1));
    chk_reg("lsl_r0", 2'd0, 16'hC000);
    chk("lsl_flags", {28'h0, bus.flags}, 32'h3);
    issue("inc_cs", enc(1'b1, 4'b1110, 4'b0110, 2'd0, 2'd0));
    chk_reg("inc_cs_r0", 2'd0, 16'hC001);
    chk("inc_cs_flags", {28'h0, bus.flags}, 32'h2);
    issue("inc_cs_skip", enc(1'b1, 4'b1110, 4'b0110, 2'd0, 2'd0));
    chk_reg("inc_skip_r0", 2'd0, 16'hC001);

    // reset while in LD_DATA aborts the load
    issue("ld_abort", enc(1'b0, 4'b0000, AL, 2'd1, 2'd2));
    step();
    rst = 1'b1;
    bus.instr_in = enc(1'b1, 4'b1110, AL, 2'd1, 2'd0);
    bus.instr_valid = 1'b1;
    step();
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    chk("abort_ready", {31'h0, bus.instr_ready}, 32'h1);
    chk("abort_we", {31'h0, bus.mem_we}, 32'h0);
    chk("abort_flags", {28'h0, bus.flags}, 32'h0);
    chk_reg("abort_r1", 2'd1, 16'h0);
    step();
    chk_reg("abort_r1_late", 2'd1, 16'h0);

    // reset beats a simultaneous store
    rst = 1'b1;
    bus.instr_in = enc(1'b0, 4'b0001, AL, 2'd0, 2'd0);
    bus.instr_valid = 1'b1;
    $display("txn st_under_reset instr=%h", bus.instr_in);
    step();
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    chk("rstwin_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rstwin_ready", {31'h0, bus.instr_ready}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_lane.md
# core_lane

Per-core execution lane: the receiving end of the 15-bit broadcast core-instruction bus driven by the instruction processor. Each lane accepts one instruction per cycle, evaluates its condition suffix against local flags, and executes ALU, move, load or store operations on a private 4-entry register file and a private single-port synchronous data RAM. Many lanes sit in parallel on the same instruction bus.

## Interface
- WIDTH, 16, data/register/address width
- INSTR_W, 15, core instruction width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr_in  in  15  core instruction
- instr_valid  in  1  instr_in valid this cycle
- instr_ready  out  1  lane can accept; high when not in a load
- mem_addr  out  WIDTH  data RAM address, registered
- mem_wdata  out  WIDTH  data RAM write data, registered
- mem_we  out  1  data RAM write enable, registered one-cycle pulse
- mem_rdata  in  WIDTH  data RAM output; valid one cycle after address is sampled
- flags  out  4  {Z,O,S,C} = bits [3:0] as ZERO=3, OVERFLOW=2, SIGN=1, CARRY=0
- dbg_sel  in  2  register select for observation
- dbg_data  out  WIDTH  combinational contents of reg[dbg_sel]

## Operation
- Encoding: [14] type (1=ALU, 0=memory/move); [13:10] op; [9:6] suffix; [5:4] reserved, ignored; [3:2] dst; [1:0] src. A=reg[dst], B=reg[src]. NOP = 15'b1_0000_1011_00_00_00.
- Suffix → condition: 0000 Z; 0001 !Z; 0010 !Z&&S==O; 0011 S!=O; 0100 S==O; 0101 Z||S!=O; 0110 C; 0111 !C; 1000 S; 1001 !S; 1010 always; 1011 never; 1100 O; 1101 !O; 1110 C&&!Z; 1111 !C||Z. Evaluated on flags as held in the accept cycle.
- Condition false: instruction consumed in one cycle, no register, flag or memory side effect. No load stall is taken.
- ALU ops, result mod 2^WIDTH into dst, all four flags updated:
  - 0000 add; 0001 addc, +C.
  - 0010 sub; 0011 subc, −C. For sub, C = borrow, meaning A<B unsigned.
  - 0100 mul, low half; 0101 mulc, low half plus C. For mul, C=O=(high half ≠0).
  - 0110 and; 0111 or; 1000 xor; 1001 not, of B. Logic ops: C=O=0.
  - 1010 lsl by B[3:0]; 1011 lsr; 1100 asr. Shifts: C = last bit shifted out, 0 if amount 0; O=0.
  - 1101 cmp: sub flags, no dst write.
  - 1110 inc A; 1111 dec A. Add-type flags.
  - Z = result==0; S = result[WIDTH-1]; O = signed overflow for add/sub/inc/dec.
- Non-ALU ops, flags unchanged:
  - 0000 load: dst ← RAM[B].
  - 0001 store: RAM[B] ← A.
  - 0010 move: dst ← B.
  - Others act as NOP.
- FSM:
  - IDLE: accept when instr_valid.
  - On an accepted, condition-true load: mem_addr ← B, go to LD_ADDR.
  - LD_ADDR → LD_DATA unconditionally.
  - LD_DATA: reg[dst] ← mem_rdata, go to IDLE.
  - instr_ready = (state==IDLE). instr_valid is ignored while not ready; the upstream holds the instruction.

## Timing
- Reset values:
  - all regs 0, flags 0, state IDLE
  - mem_we 0, mem_addr 0, mem_wdata 0
  - instr_ready 1 in the first cycle after reset
- ALU/move: accepted at edge N; dst and flags visible after edge N. The next instruction, accepted at N+1, reads the new value. No forwarding needed.
- Store: mem_we=1, mem_addr and mem_wdata valid for exactly the cycle after the accept edge. A back-to-back store keeps mem_we high with the new address and data.
- Load:
  - accept edge N: mem_addr registered
  - edge N+1: RAM samples the address
  - edge N+2: dst written
  - instr_ready low for the two cycles between
  - Total 3 cycles from accept to writeback.
- mem_addr holds its last value when idle; mem_we is 0 when no store is issued.
- Reset during LD_ADDR/LD_DATA aborts the load: no dst write, FSM returns to IDLE.
- Reset wins over a simultaneous instr_valid.
- dst==src is legal for all ops, e.g. xor r1,r1 → 0 with Z=1.

## Test plan
- Reset, then load r0←RAM[r0=0]=0x7FFF and r1←RAM[1]=0x0001 (r1 zero → addr 0). Instead, preload RAM[0]=1, load r1, then load r0 via addr r1=1 holding 0x7FFF. Then addal r0,r1 → r0=0x8000 with O=1, S=1, C=0, Z=0.
- Flags Z=0, then an addeq instruction, then a NOP → r0 unchanged, flags unchanged, instr_ready stays 1.
- subal r2,r3 with r2=0x0003, r3=0x0005 → r2=0xFFFE, C=1, S=1; then subcal r2,r3 → 0xFFF8.
- storeal r1→[r2=0x0010] with r1=0xABCD → one-cycle mem_we, mem_addr=0x0010, mem_wdata=0xABCD. Then loadal r3←[0x0010] → r3=0xABCD after 3 cycles, instr_ready low for exactly 2.
- Load followed by a held instr_valid ALU op using the loaded register → the op is accepted only after writeback and uses the loaded value.
- Reset asserted in LD_DATA → destination keeps its old value (0 after reset), mem_we=0, instr_ready=1 the next cycle.
